// File: rtl/led_activity_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : led_activity_stretcher
//  Description : Synchronises raw SoC status/debug lines and stretches every
//                rising edge to a minimum visible LED on-time, counted in
//                prescaler ticks shared by all channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_activity_stretcher #(
    parameter int CLK_MHZ     = 12,
    parameter int TICK_CYCLES = CLK_MHZ * 1000,
    parameter int HOLD_MS     = 50,
    parameter int NCH         = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [NCH-1:0] evt,
    input  logic           bypass,
    output logic [NCH-1:0] show,
    output logic           any
);

    // Prescaler width covers 0..TICK_CYCLES-1; hold counter covers 0..HOLD_MS
    // and keeps at least one bit so HOLD_MS=0 still elaborates cleanly.
    localparam int c_PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int c_CNT_W = (HOLD_MS > 0) ? $clog2(HOLD_MS + 1) : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD     = c_CNT_W'(HOLD_MS);

    logic [NCH-1:0]     r_s1;
    logic [NCH-1:0]     r_s2;
    logic [NCH-1:0]     r_s3;
    logic [c_PRE_W-1:0] r_pre;
    logic               w_tick;
    logic [NCH-1:0]     w_rise;
    logic [NCH-1:0]     w_show_nxt;

    // Two-flop synchroniser plus a third stage used only for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= evt;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    // Free-running tick prescaler; never resynchronised by channel events.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_tick = (r_pre == c_PRE_LAST);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [c_CNT_W-1:0] r_cnt;

        // Hold counter: a rise reloads the full hold (beating a coincident
        // tick), otherwise each tick takes one off until it rests at zero.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_cnt <= '0;
            end else if (w_rise[i]) begin
                r_cnt <= c_HOLD;
            end else if (w_tick && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end

        // Counters keep running under bypass, so a residual hold may show
        // once bypass is released.
        assign w_show_nxt[i] = bypass ? r_s2[i] : (r_s2[i] | (r_cnt != '0));
    end

    // Registered display outputs; any is derived from the same next value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            show <= '0;
            any  <= 1'b0;
        end else begin
            show <= w_show_nxt;
            any  <= |w_show_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_activity_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_activity_stretcher
//  Description : Self-checking bench for led_activity_stretcher (TICK=10,
//                HOLD=3, NCH=7) plus a HOLD_MS=0 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_activity_stretcher;

    localparam int c_TICK = 10;
    localparam int c_HOLD = 3;
    localparam int c_NCH  = 7;

    logic             clk    = 1'b0;
    logic             resetn = 1'b0;
    logic [c_NCH-1:0] evt    = '0;
    logic             bypass = 1'b0;
    logic [c_NCH-1:0] show;
    logic             any;
    logic [c_NCH-1:0] show0;
    logic             any0;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    led_activity_stretcher #(
        .CLK_MHZ    (12),
        .TICK_CYCLES(c_TICK),
        .HOLD_MS    (c_HOLD),
        .NCH        (c_NCH)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .evt    (evt),
        .bypass (bypass),
        .show   (show),
        .any    (any)
    );

    led_activity_stretcher #(
        .CLK_MHZ    (12),
        .TICK_CYCLES(c_TICK),
        .HOLD_MS    (0),
        .NCH        (c_NCH)
    ) u_dut0 (
        .clk    (clk),
        .resetn (resetn),
        .evt    (evt),
        .bypass (1'b0),
        .show   (show0),
        .any    (any0)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: edges are numbered from reset release; the input
    // sampled at each edge is logged, a channel is "loaded" at the edge two
    // after the sample that first reads 1, ticks fall on edges that are
    // multiples of TICK, and the remaining hold is HOLD minus ticks elapsed.
    // ------------------------------------------------------------------
    int               ecnt = 0;
    int               load_e [c_NCH];
    logic [c_NCH-1:0] samp [64];
    logic [c_NCH-1:0] exp_show = '0;
    logic [c_NCH-1:0] exp_s2   = '0;

    function automatic logic [c_NCH-1:0] sampled(input int n);
        if (n < 1) return '0;
        return samp[n % 64];
    endfunction

    function automatic bit model_rise_ch(input int e, input int ch);
        logic [c_NCH-1:0] a;
        logic [c_NCH-1:0] b;
        a = sampled(e - 2);
        b = sampled(e - 3);
        return a[ch] & ~b[ch];
    endfunction

    function automatic logic [c_NCH-1:0] model_show(input int e);
        logic [c_NCH-1:0] s2v;
        logic [c_NCH-1:0] r;
        int               rem;
        s2v = sampled(e - 2);
        r   = '0;
        for (int i = 0; i < c_NCH; i++) begin
            rem = 0;
            if (load_e[i] >= 0)
                rem = c_HOLD - ((e - 1) / c_TICK - load_e[i] / c_TICK);
            r[i] = bypass ? s2v[i] : (s2v[i] | (rem > 0));
        end
        return r;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ecnt     <= 0;
            exp_show <= '0;
            exp_s2   <= '0;
            for (int i = 0; i < c_NCH; i++) load_e[i] <= -1;
        end else begin
            ecnt                  <= ecnt + 1;
            samp[(ecnt + 1) % 64] <= evt;
            exp_show              <= model_show(ecnt + 1);
            exp_s2                <= sampled(ecnt - 1);
            for (int i = 0; i < c_NCH; i++)
                if (model_rise_ch(ecnt + 1, i)) load_e[i] <= ecnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_show", {25'd0, show}, {25'd0, exp_show});
            check("model_any", {31'd0, any}, {31'd0, |exp_show});
            check("hold0_show", {25'd0, show0}, {25'd0, exp_s2});
            check("hold0_any", {31'd0, any0}, {31'd0, |exp_s2});
        end
    end

    // One pulse on channel ch, optionally a second one sampled gap edges
    // later; checks rise latency, total on-time, single rise, side channels.
    task automatic pulse_run(input int ch, input int gap);
        int               n1, l, k, expw, w, first, rises;
        logic             prev;
        bit               side_bad;
        logic [c_NCH-1:0] m;
        m        = '0;
        m[ch]    = 1'b1;
        n1       = ecnt + 1;
        l        = (gap > 0) ? n1 + gap + 2 : n1 + 2;
        k        = c_TICK - (l % c_TICK);
        expw     = (l - (n1 + 2)) + k + (c_HOLD - 1) * c_TICK + 1;
        w        = 0;
        first    = -1;
        rises    = 0;
        prev     = 1'b0;
        side_bad = 1'b0;
        evt = m;
        @(negedge clk);
        for (int c = 1; c <= 70; c++) begin
            evt = (gap > 0 && c == gap) ? m : '0;
            @(negedge clk);
            if (show[ch]) begin
                if (first < 0) first = c;
                w++;
                if (!prev) rises++;
            end
            prev = show[ch];
            if (((show & ~m) != '0) || (any !== show[ch])) side_bad = 1'b1;
        end
        check("pulse_rise_latency", first, 2);
        check("pulse_on_time", w, expw);
        check("pulse_single_rise", rises, 1);
        check("pulse_side_chan", {31'd0, side_bad}, 32'd0);
    endtask

    typedef struct {
        logic [c_NCH-1:0] evt;
        logic [c_NCH-1:0] exp;
    } vec_t;

    vec_t tab [11];

    initial begin : main
        bit               bad;
        logic [c_NCH-1:0] v;

        // Bypass / HOLD_MS=0 vectors: show follows the input two edges later.
        tab[0]  = '{7'h00, 7'h00};
        tab[1]  = '{7'h01, 7'h00};
        tab[2]  = '{7'h00, 7'h00};
        tab[3]  = '{7'h00, 7'h01};
        tab[4]  = '{7'h7F, 7'h00};
        tab[5]  = '{7'h00, 7'h00};
        tab[6]  = '{7'h2A, 7'h7F};
        tab[7]  = '{7'h2A, 7'h00};
        tab[8]  = '{7'h00, 7'h2A};
        tab[9]  = '{7'h00, 7'h2A};
        tab[10] = '{7'h00, 7'h00};

        // Reset with all inputs high.
        evt = 7'h7F;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_show", {25'd0, show}, 32'h0);
        check("rst_any", {31'd0, any}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_edge2_show", {25'd0, show}, 32'h0);
        @(negedge clk);
        check("release_edge3_show", {25'd0, show}, 32'h7F);
        check("release_edge3_any", {31'd0, any}, 32'h1);
        evt = '0;
        repeat (40) @(negedge clk);
        check("idle_show", {25'd0, show}, 32'h0);

        // Single strobes on channel 0 at random prescaler phases.
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 9)) @(negedge clk);
            pulse_run(0, 0);
        end

        // Retrigger 15 cycles after the first pulse.
        pulse_run(2, 15);

        // Level hold for 100 cycles on channel 4.
        bad = 1'b0;
        evt = 7'h10;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (show[4] !== (c >= 2)) bad = 1'b1;
        end
        evt = '0;
        check("level_during", {31'd0, bad}, 32'h0);
        @(negedge clk);
        check("level_fall_e0", {31'd0, show[4]}, 32'h1);
        @(negedge clk);
        check("level_fall_e1", {31'd0, show[4]}, 32'h1);
        @(negedge clk);
        check("level_fall_e2", {31'd0, show[4]}, 32'h0);
        repeat (5) @(negedge clk);

        // Table-driven bypass vectors, also applied to the HOLD_MS=0 build.
        bypass = 1'b1;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 11; j++) begin
            evt = tab[j].evt;
            @(negedge clk);
            check("tab_show", {25'd0, show}, {25'd0, tab[j].exp});
            check("tab_any", {31'd0, any}, {31'd0, |tab[j].exp});
            check("tab_hold0_show", {25'd0, show0}, {25'd0, tab[j].exp});
        end
        bypass = 1'b0;
        repeat (40) @(negedge clk);

        // Reset 5 cycles into a hold on channel 1.
        evt = 7'h02;
        @(negedge clk);
        evt = '0;
        repeat (7) @(negedge clk);
        check("midhold_before", {31'd0, show[1]}, 32'h1);
        #1 resetn = 1'b0;
        #1;
        check("midhold_rst_show", {25'd0, show}, 32'h0);
        check("midhold_rst_any", {31'd0, any}, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (show !== '0 || any !== 1'b0) bad = 1'b1;
        end
        check("midhold_after_release", {31'd0, bad}, 32'h0);

        // Random traffic with occasional bypass changes against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) bypass = ~bypass;
            v = evt;
            for (int i = 0; i < c_NCH; i++)
                if ($urandom_range(0, 15) == 0) v[i] = ~v[i];
            evt = v;
        end
        bypass = 1'b0;
        evt    = '0;
        repeat (40) @(negedge clk);
        check("final_idle", {25'd0, show}, 32'h0);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench did not complete");
    end

endmodule
`default_nettype wire
